// File: rtl/uart_pkg.sv
// Shared constants, formatter state encoding and the nibble-to-ASCII helper
// for the UART hex dumper.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO
  } fmt_state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end
    return (upper ? ASCII_UA : ASCII_LA) + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO; the head entry is presented on dout whenever the
// FIFO is not empty. Pushes while full and pops while empty are ignored.
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_dumper.sv
// Buffers binary words and writes each to a byte UART as ASCII hex digits,
// MSB nibble first, followed by CR LF, one character per write strobe.
module uart_hex_dumper
  import uart_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit UPPERCASE  = 1'b1
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_n_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_dat_i,
  output logic              word_ready_o,
  input  logic              uart_busy_i,
  output logic              uart_wr_o,
  output logic [7:0]        uart_dat_o,
  output logic              idle_o
);
  localparam int NIBBLES = WORD_W / 4;
  localparam int CHARS   = NIBBLES + 2;
  localparam int CW      = $clog2(CHARS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CHARS - 1);
  localparam logic [CW-1:0] CR_CNT   = CW'(NIBBLES);

  fmt_state_t        r_state;
  fmt_state_t        w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [7:0]        r_dat;
  logic [7:0]        w_char;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_head;

  sync_word_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (sys_clk_i),
    .rst_n(sys_rst_n_i),
    .push (word_valid_i),
    .din  (word_dat_i),
    .pop  (w_pop),
    .full (w_full),
    .empty(w_empty),
    .dout (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_pop       = 1'b1;
        w_shift_nxt = w_head;
        w_cnt_nxt   = '0;
        w_state_nxt = SEND;
      end
      SEND:    w_state_nxt = WAIT_HI;
      // WAIT_HI never looks at busy: the UART only raises it one edge after the strobe.
      WAIT_HI: w_state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (!uart_busy_i) begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = SEND;
            if (r_cnt < CR_CNT) w_shift_nxt = r_shift << 4;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Character for the upcoming SEND, computed from the values it will see.
  always_comb begin
    w_char = ASCII_LF;
    if (w_cnt_nxt < CR_CNT) begin
      w_char = nibble_to_ascii(w_shift_nxt[WORD_W-1 -: 4], UPPERCASE);
    end else if (w_cnt_nxt == CR_CNT) begin
      w_char = ASCII_CR;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dat   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_state_nxt == SEND) r_dat <= w_char;
    end
  end

  assign uart_wr_o    = (r_state == SEND);
  assign uart_dat_o   = r_dat;
  assign word_ready_o = !w_full;
  assign idle_o       = w_empty && (r_state == IDLE);

endmodule

// File: tb/tb_uart_hex_dumper.sv
// Bench for uart_hex_dumper: three instances (uppercase 32-bit, lowercase
// 32-bit, uppercase 8-bit), each with a UART busy responder and char capture.
module tb_uart_hex_dumper;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic [31:0] dat_a = '0, dat_b = '0;
  logic [7:0]  dat_c = '0;
  logic        ready_a, ready_b, ready_c;
  logic        idle_a, idle_b, idle_c;
  logic [2:0]  busy = '0;
  wire  [2:0]  wr;
  wire  [2:0][7:0] ch;

  uart_hex_dumper #(.WORD_W(32), .FIFO_DEPTH(4), .UPPERCASE(1'b1)) dut_a (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .word_valid_i(valid_a), .word_dat_i(dat_a),
    .word_ready_o(ready_a), .uart_busy_i(busy[0]), .uart_wr_o(wr[0]),
    .uart_dat_o(ch[0]), .idle_o(idle_a));

  uart_hex_dumper #(.WORD_W(32), .FIFO_DEPTH(4), .UPPERCASE(1'b0)) dut_b (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .word_valid_i(valid_b), .word_dat_i(dat_b),
    .word_ready_o(ready_b), .uart_busy_i(busy[1]), .uart_wr_o(wr[1]),
    .uart_dat_o(ch[1]), .idle_o(idle_b));

  uart_hex_dumper #(.WORD_W(8), .FIFO_DEPTH(4), .UPPERCASE(1'b1)) dut_c (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .word_valid_i(valid_c), .word_dat_i(dat_c),
    .word_ready_o(ready_c), .uart_busy_i(busy[2]), .uart_wr_o(wr[2]),
    .uart_dat_o(ch[2]), .idle_o(idle_c));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q0[$], exp_q1[$], exp_q2[$];
  logic [7:0] got_q0[$], got_q1[$], got_q2[$];
  int         strobe_cyc_q0[$];

  // UART responder: a strobe in cycle t makes busy visible from edge t+2 for
  // blen sampled edges, matching a UART that raises busy on the edge after a write.
  int         busy_len = 3;
  int         once_len = 0;
  bit         rand_busy = 1'b0;
  int         pend[3];
  int         left[3];
  int         blen_m;
  int         fall_cyc = 0;
  int         n_busy_viol = 0, n_b2b_viol = 0, n_hold_viol = 0;
  logic [2:0] prev_wr = '0;
  logic [7:0] last_ch[3];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy    = '0;
      prev_wr = '0;
      for (int i = 0; i < 3; i++) begin
        pend[i]    = 0;
        left[i]    = 0;
        last_ch[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr[i]) begin
          if (busy[i]) n_busy_viol++;
          if (prev_wr[i]) n_b2b_viol++;
          last_ch[i] = ch[i];
          case (i)
            0: begin got_q0.push_back(ch[i]); strobe_cyc_q0.push_back(cyc); end
            1: got_q1.push_back(ch[i]);
            default: got_q2.push_back(ch[i]);
          endcase
          blen_m = 3;
          if (i == 0) begin
            blen_m = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
            if (once_len > 0) begin
              blen_m   = once_len;
              once_len = 0;
            end
          end
          pend[i] = blen_m;
        end else begin
          if (ch[i] !== last_ch[i]) n_hold_viol++;
          if (pend[i] > 0) begin
            busy[i] = 1'b1;
            left[i] = pend[i];
            pend[i] = 0;
          end else if (left[i] > 0) begin
            left[i]--;
            if (left[i] == 0) begin
              busy[i] = 1'b0;
              if (i == 0) fall_cyc = cyc;
            end
          end
        end
        prev_wr[i] = wr[i];
      end
    end
  end

  // Reference: hex digits of the word, most significant first, then CR LF.
  task automatic expect_line(input int inst, input logic [31:0] w, input int ww, input bit upper);
    logic [7:0] line[$];
    for (int i = ww / 4 - 1; i >= 0; i--) begin
      int n;
      n = int'((w >> (4 * i)) & 32'hF);
      if (n < 10) line.push_back(8'(48 + n));
      else line.push_back(8'((upper ? 65 : 97) + n - 10));
    end
    line.push_back(8'h0D);
    line.push_back(8'h0A);
    foreach (line[j]) begin
      case (inst)
        0: exp_q0.push_back(line[j]);
        1: exp_q1.push_back(line[j]);
        default: exp_q2.push_back(line[j]);
      endcase
    end
  endtask

  function automatic logic ready_of(input int inst);
    case (inst)
      0: return ready_a;
      1: return ready_b;
      default: return ready_c;
    endcase
  endfunction

  // Holds valid high until accepted; returns at the negedge after the accepting edge.
  task automatic push_word(input int inst, input logic [31:0] w, output int acc);
    int t = 0;
    case (inst)
      0: begin valid_a = 1'b1; dat_a = w; end
      1: begin valid_b = 1'b1; dat_b = w; end
      default: begin valid_c = 1'b1; dat_c = w[7:0]; end
    endcase
    while (!ready_of(inst) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    acc = cyc;
    n_checks++;
    if (t >= 5000) $display("FAIL push_timeout: inst %0d word %08h ready never rose within %0d cycles", inst, w, t);
    else n_pass++;
    expect_line(inst, w, (inst == 2) ? 8 : 32, inst != 1);
  endtask

  task automatic wait_done(input int inst, input int budget, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < budget) begin
      @(negedge clk);
      t++;
      case (inst)
        0: ok = idle_a && (got_q0.size() >= exp_q0.size());
        1: ok = idle_b && (got_q1.size() >= exp_q1.size());
        default: ok = idle_c && (got_q2.size() >= exp_q2.size());
      endcase
      if (ok) break;
    end
  endtask

  task automatic clear_sb();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    got_q0.delete(); got_q1.delete(); got_q2.delete();
    strobe_cyc_q0.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr !== 3'b000) $display("FAIL reset_wr: got %b expected 000", wr); else n_pass++;
    n_checks++; if (ch[0] !== 8'h00) $display("FAIL reset_dat: got %02h expected 00", ch[0]); else n_pass++;
    n_checks++; if ({ready_a, ready_b, ready_c} !== 3'b111) $display("FAIL reset_ready: got %b expected 111", {ready_a, ready_b, ready_c}); else n_pass++;
    n_checks++; if ({idle_a, idle_b, idle_c} !== 3'b111) $display("FAIL reset_idle: got %b expected 111", {idle_a, idle_b, idle_c}); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (idle_a !== 1'b1 || wr[0] !== 1'b0) $display("FAIL post_reset: idle %b wr %b expected 1 0", idle_a, wr[0]); else n_pass++;
  endtask

  task automatic test_deadbeef();
    int acc;
    bit ok;
    int bad_gap = 0;
    clear_sb();
    busy_len = 20;
    push_word(0, 32'hDEADBEEF, acc);
    valid_a = 1'b0;
    wait_done(0, 3000, ok);
    n_checks++; if (!ok) $display("FAIL deadbeef_done: got %0d chars expected %0d before timeout", got_q0.size(), exp_q0.size()); else n_pass++;
    n_checks++; if (got_q0.size() != 10) $display("FAIL deadbeef_len: got %0d expected 10", got_q0.size()); else n_pass++;
    for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++) begin
      n_checks++; if (got_q0[i] !== exp_q0[i]) $display("FAIL deadbeef_char%0d: got %02h expected %02h", i, got_q0[i], exp_q0[i]); else n_pass++;
    end
    n_checks++;
    if (strobe_cyc_q0.size() == 0 || strobe_cyc_q0[0] != acc + 2) $display("FAIL deadbeef_latency: first strobe cycle %0d expected %0d", (strobe_cyc_q0.size() > 0) ? strobe_cyc_q0[0] : -1, acc + 2);
    else n_pass++;
    for (int i = 1; i < strobe_cyc_q0.size(); i++) if (strobe_cyc_q0[i] - strobe_cyc_q0[i-1] != 22) bad_gap++;
    n_checks++; if (bad_gap != 0) $display("FAIL deadbeef_spacing: %0d strobe gaps differ from 22 cycles", bad_gap); else n_pass++;
    n_checks++; if (idle_a !== 1'b1) $display("FAIL deadbeef_idle: got %b expected 1", idle_a); else n_pass++;
    n_checks++; if (n_busy_viol + n_b2b_viol + n_hold_viol != 0) $display("FAIL deadbeef_protocol: busy %0d b2b %0d hold %0d expected 0", n_busy_viol, n_b2b_viol, n_hold_viol); else n_pass++;
    busy_len = 3;
  endtask

  task automatic test_lowercase();
    int acc;
    bit ok;
    clear_sb();
    push_word(1, 32'h0000ABCD, acc);
    valid_b = 1'b0;
    wait_done(1, 2000, ok);
    n_checks++; if (!ok || got_q1.size() != 10) $display("FAIL lower_len: got %0d chars expected 10 (done %b)", got_q1.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q1.size() && i < got_q1.size(); i++) begin
      n_checks++; if (got_q1[i] !== exp_q1[i]) $display("FAIL lower_char%0d: got %02h expected %02h", i, got_q1[i], exp_q1[i]); else n_pass++;
    end
  endtask

  task automatic test_byte();
    int acc;
    bit ok;
    clear_sb();
    push_word(2, 32'h0000007F, acc);
    valid_c = 1'b0;
    wait_done(2, 2000, ok);
    n_checks++; if (!ok || got_q2.size() != 4) $display("FAIL byte_len: got %0d chars expected 4 (done %b)", got_q2.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q2.size() && i < got_q2.size(); i++) begin
      n_checks++; if (got_q2[i] !== exp_q2[i]) $display("FAIL byte_char%0d: got %02h expected %02h", i, got_q2[i], exp_q2[i]); else n_pass++;
    end
    n_checks++; if (idle_c !== 1'b1) $display("FAIL byte_idle: got %b expected 1", idle_c); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc[6];
    logic [31:0] w;
    bit ok;
    bit full_seen;
    clear_sb();
    busy_len = 3;
    for (int i = 0; i < 6; i++) begin
      w = ($urandom & 32'hFFFF_FFF0) | 32'(i);
      push_word(0, w, acc[i]);
      if (i == 4) full_seen = !ready_a;
    end
    valid_a = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (acc[i] != acc[0] + i) $display("FAIL b2b_accept%0d: cycle %0d expected %0d", i, acc[i], acc[0] + i); else n_pass++;
    end
    n_checks++; if (!full_seen) $display("FAIL b2b_full: ready stayed 1 after five words, expected 0"); else n_pass++;
    n_checks++;
    if (strobe_cyc_q0.size() < 11 || acc[5] != strobe_cyc_q0[10] + 1) $display("FAIL b2b_sixth: accepted cycle %0d expected %0d", acc[5], (strobe_cyc_q0.size() > 10) ? strobe_cyc_q0[10] + 1 : -1);
    else n_pass++;
    wait_done(0, 3000, ok);
    n_checks++; if (!ok || got_q0.size() != 60) $display("FAIL b2b_len: got %0d chars expected 60 (done %b)", got_q0.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++) begin
      n_checks++; if (got_q0[i] !== exp_q0[i]) $display("FAIL b2b_char%0d: got %02h expected %02h", i, got_q0[i], exp_q0[i]); else n_pass++;
    end
  endtask

  task automatic test_busy_hold();
    int acc;
    int t = 0;
    bit ok;
    clear_sb();
    once_len = 1000;
    push_word(0, $urandom, acc);
    valid_a = 1'b0;
    while (got_q0.size() < 2 && t < 1200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (got_q0.size() < 2 || strobe_cyc_q0[1] != strobe_cyc_q0[0] + 1002) $display("FAIL hold_quiet: %0d strobes, second at %0d expected %0d", got_q0.size(), (strobe_cyc_q0.size() > 1) ? strobe_cyc_q0[1] : -1, (strobe_cyc_q0.size() > 0) ? strobe_cyc_q0[0] + 1002 : -1);
    else n_pass++;
    n_checks++;
    if (strobe_cyc_q0.size() < 2 || strobe_cyc_q0[1] != fall_cyc + 1) $display("FAIL hold_resume: second strobe cycle %0d expected %0d", (strobe_cyc_q0.size() > 1) ? strobe_cyc_q0[1] : -1, fall_cyc + 1);
    else n_pass++;
    wait_done(0, 2000, ok);
    n_checks++; if (!ok || got_q0.size() != 10) $display("FAIL hold_len: got %0d chars expected 10 (done %b)", got_q0.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++) begin
      n_checks++; if (got_q0[i] !== exp_q0[i]) $display("FAIL hold_char%0d: got %02h expected %02h", i, got_q0[i], exp_q0[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_midline();
    int acc;
    int t = 0;
    bit ok;
    clear_sb();
    busy_len = 5;
    push_word(0, $urandom, acc);
    valid_a = 1'b0;
    while (got_q0.size() < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++; if (got_q0.size() < 3) $display("FAIL midreset_setup: got %0d chars expected 3", got_q0.size()); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (wr[0] !== 1'b0) $display("FAIL midreset_wr: got %b expected 0", wr[0]); else n_pass++;
    n_checks++; if (idle_a !== 1'b1 || ready_a !== 1'b1) $display("FAIL midreset_flags: idle %b ready %b expected 1 1", idle_a, ready_a); else n_pass++;
    n_checks++; if (ch[0] !== 8'h00) $display("FAIL midreset_dat: got %02h expected 00", ch[0]); else n_pass++;
    repeat (2) @(negedge clk);
    clear_sb();
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (got_q0.size() != 0) $display("FAIL midreset_leftover: got %0d chars expected 0", got_q0.size()); else n_pass++;
    push_word(0, 32'h12345678, acc);
    valid_a = 1'b0;
    wait_done(0, 2000, ok);
    n_checks++; if (!ok || got_q0.size() != 10) $display("FAIL midreset_len: got %0d chars expected 10 (done %b)", got_q0.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++) begin
      n_checks++; if (got_q0[i] !== exp_q0[i]) $display("FAIL midreset_char%0d: got %02h expected %02h", i, got_q0[i], exp_q0[i]); else n_pass++;
    end
    busy_len = 3;
  endtask

  task automatic test_random();
    int acc;
    int gap;
    bit ok;
    clear_sb();
    rand_busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_word(0, $urandom, acc);
      valid_a = 1'b0;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      push_word(2, $urandom, acc);
      valid_c = 1'b0;
    end
    wait_done(0, 5000, ok);
    n_checks++; if (!ok || got_q0.size() != exp_q0.size()) $display("FAIL rand_len: got %0d chars expected %0d (done %b)", got_q0.size(), exp_q0.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++) begin
      n_checks++; if (got_q0[i] !== exp_q0[i]) $display("FAIL rand_char%0d: got %02h expected %02h", i, got_q0[i], exp_q0[i]); else n_pass++;
    end
    wait_done(2, 2000, ok);
    n_checks++; if (!ok || got_q2.size() != exp_q2.size()) $display("FAIL rand_byte_len: got %0d chars expected %0d (done %b)", got_q2.size(), exp_q2.size(), ok); else n_pass++;
    for (int i = 0; i < exp_q2.size() && i < got_q2.size(); i++) begin
      n_checks++; if (got_q2[i] !== exp_q2[i]) $display("FAIL rand_byte_char%0d: got %02h expected %02h", i, got_q2[i], exp_q2[i]); else n_pass++;
    end
    n_checks++; if (n_busy_viol + n_b2b_viol + n_hold_viol != 0) $display("FAIL protocol: busy %0d b2b %0d hold %0d expected 0", n_busy_viol, n_b2b_viol, n_hold_viol); else n_pass++;
    rand_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_lowercase();
    test_byte();
    test_back_to_back();
    test_busy_hold();
    test_reset_midline();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
